// File: rtl/eic_input_filter.sv
// Per-channel synchronizer and glitch filter feeding the eic signal vector.
// A level change is passed only after staying stable for filter_len cycles.
module eic_input_filter #(
    parameter int unsigned CHANNELS     = 32,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned FILTER_WIDTH = 4
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [CHANNELS-1:0]     raw_in,
    input  logic [CHANNELS-1:0]     filter_en,
    input  logic [FILTER_WIDTH-1:0] filter_len,
    output logic [CHANNELS-1:0]     signal,
    output logic [CHANNELS-1:0]     rise,
    output logic [CHANNELS-1:0]     fall
);

    localparam logic [FILTER_WIDTH-1:0] CntOne = FILTER_WIDTH'(1);

    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("eic_input_filter: SYNC_STAGES must be at least 2");
    end

    logic [CHANNELS-1:0]     sync_q [SYNC_STAGES];
    logic [FILTER_WIDTH-1:0] cnt_q  [CHANNELS];
    logic [FILTER_WIDTH-1:0] cnt_d  [CHANNELS];
    logic [CHANNELS-1:0]     signal_q, signal_d;
    logic [CHANNELS-1:0]     rise_q, fall_q;
    logic [CHANNELS-1:0]     sync_last;
    logic [FILTER_WIDTH-1:0] len_m1;
    logic                    len_zero;

    assign sync_last = sync_q[SYNC_STAGES-1];
    assign len_zero  = (filter_len == '0);
    assign len_m1    = filter_len - CntOne;

    // The >= compare lets a shortened filter_len finish a count in progress.
    always_comb begin
        signal_d = signal_q;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_d[i] = '0;
            if (!filter_en[i] || len_zero) begin
                signal_d[i] = sync_last[i];
            end else if (sync_last[i] == signal_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] >= len_m1) begin
                signal_d[i] = sync_last[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CntOne;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync_q   <= '{default: '0};
            cnt_q    <= '{default: '0};
            signal_q <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
        end else begin
            sync_q[0] <= raw_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            cnt_q    <= cnt_d;
            signal_q <= signal_d;
            rise_q   <= signal_d & ~signal_q;
            fall_q   <= ~signal_d & signal_q;
        end
    end

    assign signal = signal_q;
    assign rise   = rise_q;
    assign fall   = fall_q;

endmodule

// File: doc/eic_input_filter.md
# eic_input_filter

Per-channel input conditioner that sits directly upstream of the `eic` interrupt controller and drives its `signal` vector. Each raw interrupt line is synchronized into `CLK` through a flop chain, then glitch-filtered: a level change reaches the output only after it has been stable for a programmable number of cycles. The block also emits one-cycle rise/fall strobes per channel for sense logic or debug. There is no bus interface; `filter_len` and `filter_en` are static or slowly changing control inputs.

## Interface
Parameters:
- `CHANNELS`, 32: number of input lines; sets the width of every per-channel port.
- `SYNC_STAGES`, 2: synchronizer depth, minimum 2.
- `FILTER_WIDTH`, 4: width of `filter_len` and of each per-channel stability counter.

Ports:
- `CLK`  in  1: single clock, rising-edge.
- `RESET`  in  1: synchronous, active-high reset.
- `raw_in`  in  CHANNELS: asynchronous external interrupt lines.
- `filter_en`  in  CHANNELS: per-channel filter enable; 0 gives synchronizer-only operation.
- `filter_len`  in  FILTER_WIDTH: required stable-cycle count N, shared by all channels.
- `signal`  out  CHANNELS: conditioned levels; connects to `eic.signal`.
- `rise`  out  CHANNELS: one-cycle strobe when `signal[i]` goes 0->1.
- `fall`  out  CHANNELS: one-cycle strobe when `signal[i]` goes 1->0.

## Operation
- Synchronizer: `SYNC_STAGES` flops per channel. `sync[i]` is the last stage.
- Filter state per channel: counter `cnt[i]` (FILTER_WIDTH bits) and output register `signal[i]`.
- Bypass applies when `filter_en[i]`=0 or `filter_len`=0. In bypass, `signal[i]` <= `sync[i]` every cycle and `cnt[i]` <= 0.
- Filtered, with N = `filter_len` >= 1, priority order:
  - `sync[i]` == `signal[i]`: `cnt[i]` <= 0. Any partial count is discarded, so a glitch shorter than N cycles is fully rejected.
  - else if `cnt[i]` >= N-1: `signal[i]` <= `sync[i]` and `cnt[i]` <= 0. The >= compare means lowering `filter_len` during a count completes the transition immediately.
  - else: `cnt[i]` <= `cnt[i]`+1. The counter cannot wrap, because it clears at or before N-1 <= 2^FILTER_WIDTH-2.
- Strobes:
  - `rise[i]` is registered and equals 1 in exactly the cycle following the edge on which `signal[i]` was loaded 0->1.
  - `fall[i]` behaves the same for 1->0.
  - `rise[i]` and `fall[i]` are never both 1.
- Channels are fully independent. Simultaneous changes on any set of channels are handled in parallel with no arbitration.
- Toggling `filter_en[i]` mid-count:
  - 1->0: bypass takes effect on the next edge and the counter clears.
  - 0->1: filtering starts with `cnt[i]`=0.

## Timing
- Reset: on any edge with `RESET`=1, all synchronizer flops, `cnt`, `signal`, `rise` and `fall` are cleared to 0. Reset mid-count discards the pending transition.
- After `RESET` deasserts with `raw_in[i]`=1, the channel rises with normal latency, counted from the first non-reset edge.
- Define edge k as the first edge at which the new `raw_in[i]` level is sampled by the first synchronizer stage.
- Bypass latency: `signal[i]` updates at edge k+SYNC_STAGES. `rise`/`fall` are visible in the following cycle, coincident with `signal`.
- Filtered latency: `signal[i]` updates at edge k+SYNC_STAGES-1+N, given that the level is held without interruption.
- A pulse is rejected when its synchronized width is < N cycles. It is passed when its width is >= N.
- Minimum output pulse width equals N cycles in filtered mode and 1 cycle in bypass.
- No combinational path exists from any input to any output.

## Test plan
- Reset and bypass (`filter_en`=0, SYNC_STAGES=2):
  - `raw_in`=0x0000_0021 held during reset -> all outputs 0 during reset.
  - After release -> `signal`=0x21 at edge 2, `rise`=0x21 for exactly one cycle.
- Filter pass (N=4, `filter_en`=all 1s): `raw_in[12]` steps 0->1 -> `signal[12]` rises at edge k+5, `rise[12]` pulses once, `cnt[12]` returns to 0.
- Glitch reject (N=4): `raw_in[5]` high for 3 cycles then low -> `signal[5]` stays 0, and `rise` and `fall` stay 0 throughout.
- Interrupted count (N=4): `raw_in[0]` goes high 2 cycles, low 1, high 4 -> single rise at 4 cycles after the restart plus sync delay, with no earlier rise.
- Falling edge with mixed channels:
  - `raw_in[12]` and `raw_in[5]` both drop in the same cycle.
  - `filter_en`=0x0000_1000.
  - Response: `fall[5]` at edge k+2, `fall[12]` at edge k+5.
- Mid-operation changes:
  - `filter_len` changes 8->2 while `cnt`=5 -> transition completes on the next edge.
  - `RESET` asserted mid-count -> all outputs 0, and no strobe after release unless the input differs from 0.
